bus_resp_regs: RTL and testbench

- Generic data-bus responder (slave end) for the CPU data-side req/gnt/rvalid protocol.
- Sits behind the address decoder as one selected target.
- Implements a small memory-mapped register bank with a read-only ID word, byte-enabled writes, programmable wait states and error responses.
- Register contents are exported flat for use by peripheral logic.

---
 rtl/bus_resp_regs.sv | 109 ++++++++++
 tb/tb_bus_resp_regs.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_resp_regs.sv
// Data-bus responder: req/gnt/rvalid target with an ID word, byte-enabled RW
// registers, programmable grant wait states and error responses.
module bus_resp_regs #(
  parameter int          N_REGS      = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h1BE0_0001,
  parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic                  gnt,
  output logic                  rvalid,
  output logic [31:0]           rdata,
  output logic                  err,
  output logic [32*N_REGS-1:0]  regs_o
);

  localparam int IW = (N_REGS > 1) ? $clog2(N_REGS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                     r_state;
  logic [3:0]                 r_cnt;
  logic [N_REGS-1:1][31:0]    r_rw;

  logic [9:0]                 w_idx;
  logic [IW-1:0]              w_sel;
  logic                       w_err;
  logic                       w_wr;
  logic [N_REGS-1:0][31:0]    w_words;
  logic                       w_unused;

  assign w_idx    = addr[11:2];
  assign w_sel    = w_idx[IW-1:0];
  assign w_err    = ({1'b0, w_idx} >= 11'(N_REGS)) || (we && (w_idx == 10'd0));
  assign w_wr     = gnt && we && !w_err;
  assign w_unused = ^{addr[31:12], addr[1:0]};

  always_comb begin
    w_words[0] = ID_VALUE;
    for (int k = 1; k < N_REGS; k++) w_words[k] = r_rw[k];
  end

  assign regs_o = w_words;

  // Grant is combinational so it lands in the same cycle as the qualifying req;
  // gated by reset so nothing is granted while the block is held in reset.
  always_comb begin
    gnt = 1'b0;
    if (Rst_n) begin
      case (r_state)
        S_IDLE:  gnt = req && (WAIT_STATES == 0);
        S_WAIT:  gnt = req && (r_cnt == 4'd1);
        default: gnt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      rvalid <= gnt;
      if (gnt) begin
        err   <= w_err;
        rdata <= (w_err || we) ? 32'h0 : w_words[w_sel];
      end
      case (r_state)
        S_IDLE: begin
          if (req) begin
            if (WAIT_STATES == 0) begin
              r_state <= S_RESP;
            end else begin
              r_cnt   <= 4'(WAIT_STATES);
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          // A dropped req abandons the access without any response.
          if (!req)                r_state <= S_IDLE;
          else if (r_cnt == 4'd1)  r_state <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int k = 1; k < N_REGS; k++) r_rw[k] <= RESET_VAL;
    end else if (w_wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) r_rw[w_sel][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_bus_resp_regs.sv
// Bench for bus_resp_regs: three instances (1, 0 and 3 wait states) driven by
// directed and random accesses; a monitor checks responses against a queue.
module tb_bus_resp_regs;

  localparam logic [31:0] ID = 32'h1BE0_0001;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   req, gnt, rvalid, err;
  logic         we;
  logic [3:0]   be;
  logic [31:0]  addr, wdata;
  logic [31:0]  rdata [3];
  logic [255:0] regs_o [3];

  always #5 clk = ~clk;

  bus_resp_regs #(.N_REGS(8), .WAIT_STATES(1)) u_ws1 (
    .Clk(clk), .Rst_n(rst_n), .req(req[0]), .we(we), .be(be), .addr(addr),
    .wdata(wdata), .gnt(gnt[0]), .rvalid(rvalid[0]), .rdata(rdata[0]),
    .err(err[0]), .regs_o(regs_o[0]));

  bus_resp_regs #(.N_REGS(8), .WAIT_STATES(0)) u_ws0 (
    .Clk(clk), .Rst_n(rst_n), .req(req[1]), .we(we), .be(be), .addr(addr),
    .wdata(wdata), .gnt(gnt[1]), .rvalid(rvalid[1]), .rdata(rdata[1]),
    .err(err[1]), .regs_o(regs_o[1]));

  bus_resp_regs #(.N_REGS(8), .WAIT_STATES(3)) u_ws3 (
    .Clk(clk), .Rst_n(rst_n), .req(req[2]), .we(we), .be(be), .addr(addr),
    .wdata(wdata), .gnt(gnt[2]), .rvalid(rvalid[2]), .rdata(rdata[2]),
    .err(err[2]), .regs_o(regs_o[2]));

  typedef struct {
    int          dut;
    logic [31:0] rd;
    logic        e;
  } exp_t;

  exp_t        sbq [$];
  logic [31:0] mem [3][8];
  int          n_chk = 0;
  int          n_fail = 0;
  bit          b2b [3];

  function automatic int ws_of(int j);
    return (j == 0) ? 1 : ((j == 1) ? 0 : 3);
  endfunction

  function automatic logic [255:0] model_flat(int j);
    logic [255:0] f;
    for (int k = 0; k < 8; k++) f[32*k +: 32] = (k == 0) ? ID : mem[j][k];
    return f;
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic clear_model();
    for (int j = 0; j < 3; j++)
      for (int k = 0; k < 8; k++) mem[j][k] = 32'h0;
    for (int j = 0; j < 3; j++) b2b[j] = 1'b0;
  endtask

  task automatic rand_bus();
    we    = 1'($urandom());
    be    = 4'($urandom());
    addr  = $urandom();
    wdata = $urandom();
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    if (n > 0) for (int j = 0; j < 3; j++) b2b[j] = 1'b0;
  endtask

  // Response checker: every rvalid must follow a grant by one cycle and match
  // the oldest queued expectation for that instance.
  task automatic monitor();
    bit [2:0] pg = 3'b000;
    exp_t     e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pg = 3'b000;
      end else begin
        for (int j = 0; j < 3; j++) begin
          if (rvalid[j] || pg[j]) chk($sformatf("rvalid_after_gnt%0d", j), rvalid[j], pg[j]);
          if (rvalid[j]) begin
            if (sbq.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL unexpected_rvalid dut%0d: got rvalid=1 expected no response", j);
            end else begin
              e = sbq.pop_front();
              chk("resp_dut", j, e.dut);
              chk($sformatf("rdata%0d", j), rdata[j], e.rd);
              chk($sformatf("err%0d", j), err[j], e.e);
              chk($sformatf("regs_o%0d", j), regs_o[j], model_flat(j));
            end
          end
        end
        pg = gnt;
      end
    end
  endtask

  task automatic do_txn(int j, bit w, logic [3:0] b, logic [31:0] a, logic [31:0] d);
    int       lat;
    int       exp_lat;
    logic [9:0] idx;
    exp_t     e;
    bit       errx;
    exp_lat = ws_of(j) + (b2b[j] ? 1 : 0);
    for (int k = 0; k < 3; k++) b2b[k] = 1'b0;
    we = w; be = b; addr = a; wdata = d;
    req[j] = 1'b1;
    lat = 0;
    while (1) begin
      @(negedge clk);
      if (gnt[j]) break;
      lat++;
      if (lat > 30) begin
        n_chk++;
        n_fail++;
        $display("FAIL gnt_timeout dut%0d: got no gnt expected gnt after %0d cycles", j, exp_lat);
        req[j] = 1'b0;
        return;
      end
    end
    chk($sformatf("gnt_latency%0d", j), lat, exp_lat);
    idx  = a[11:2];
    errx = (idx >= 8) || (w && idx == 0);
    e.dut = j;
    e.e   = errx;
    e.rd  = 32'h0;
    if (!errx) begin
      if (w) begin
        for (int bb = 0; bb < 4; bb++)
          if (b[bb]) mem[j][idx[2:0]][8*bb +: 8] = d[8*bb +: 8];
      end else begin
        e.rd = (idx == 0) ? ID : mem[j][idx[2:0]];
      end
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    req[j] = 1'b0;
    rand_bus();
    b2b[j] = 1'b1;
  endtask

  initial begin
    req = 3'b000;
    rand_bus();
    clear_model();
    fork
      monitor();
    join_none

    // Reset state, including grant suppression with req high during reset.
    #12;
    req = 3'b111;
    #1;
    chk("reset_gnt", gnt, 3'b000);
    chk("reset_rvalid", rvalid, 3'b000);
    chk("reset_err", err, 3'b000);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("reset_rdata%0d", j), rdata[j], 32'h0);
      chk($sformatf("reset_regs%0d", j), regs_o[j], model_flat(j));
    end
    req = 3'b000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Directed accesses on the one-wait-state instance.
    do_txn(0, 1'b0, 4'hF, 32'h0000_0000, 32'h0);
    idle(1);
    do_txn(0, 1'b1, 4'b0101, 32'h0000_0004, 32'hDEAD_BEEF);
    idle(1);
    do_txn(0, 1'b0, 4'h0, 32'h0000_0004, 32'h0);
    idle(1);
    chk("word1_after_be_write", regs_o[0][63:32], 32'h00AD_00EF);
    do_txn(0, 1'b1, 4'hF, 32'h0000_0000, 32'hFFFF_FFFF);
    idle(1);
    do_txn(0, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
    idle(2);
    chk("id_word_unchanged", regs_o[0][31:0], ID);

    // Zero wait states, req held across three back-to-back accesses.
    do_txn(1, 1'b0, 4'hF, 32'h0000_0000, 32'h0);
    do_txn(1, 1'b1, 4'hF, 32'h0000_0008, 32'hA5A5_5A5A);
    do_txn(1, 1'b0, 4'hF, 32'h0000_0008, 32'h0);
    idle(2);

    // Three wait states, req withdrawn after two cycles.
    req[2] = 1'b1;
    @(negedge clk);
    chk("abandon_gnt_c0", gnt[2], 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abandon_gnt_c1", gnt[2], 1'b0);
    @(posedge clk);
    #1;
    req[2] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abandon_gnt_after", gnt[2], 1'b0);
      chk("abandon_rvalid_after", rvalid[2], 1'b0);
    end
    idle(1);
    do_txn(2, 1'b0, 4'hF, 32'h0000_0000, 32'h0);
    idle(1);
    do_txn(2, 1'b1, 4'hF, 32'h0000_0008, 32'h1234_5678);
    idle(1);
    do_txn(2, 1'b0, 4'hF, 32'h0000_0008, 32'h0);
    idle(1);

    // Reset while a write is waiting for its grant.
    we = 1'b1; be = 4'hF; addr = 32'h0000_0008; wdata = 32'hFFFF_FFFF;
    req[2] = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_gnt", gnt, 3'b000);
    chk("abort_rvalid", rvalid, 3'b000);
    chk("abort_err", err, 3'b000);
    for (int j = 0; j < 3; j++) chk($sformatf("abort_rdata%0d", j), rdata[j], 32'h0);
    chk("abort_word2", regs_o[2][95:64], 32'h0);
    clear_model();
    req[2] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    chk("abort_regs_after", regs_o[2], model_flat(2));

    // Random traffic across all three instances.
    repeat (60) begin
      int          j;
      logic [31:0] a;
      a = $urandom();
      a[11:2] = 10'($urandom_range(0, 9));
      j = $urandom_range(0, 2);
      idle($urandom_range(0, 2));
      do_txn(j, 1'($urandom()), 4'($urandom()), a, $urandom());
    end
    idle(4);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
